// File: rtl/seven_seg_capture_if.sv
// Bundles the multiplexed display bus, the capture clear and the decoded
// per-digit results of seven_seg_capture.
interface seven_seg_capture_if;
    logic [6:0] segment_in;
    logic [3:0] anode_in;
    logic       clear;
    logic [3:0] digitA;
    logic [3:0] digitB;
    logic [3:0] digitC;
    logic [3:0] digitD;
    logic [3:0] digit_valid;
    logic [3:0] pattern_err;
    logic       anode_err;
    logic       frame_valid;

    modport master (
        output segment_in, anode_in, clear,
        input  digitA, digitB, digitC, digitD, digit_valid, pattern_err,
               anode_err, frame_valid
    );

    modport slave (
        input  segment_in, anode_in, clear,
        output digitA, digitB, digitC, digitD, digit_valid, pattern_err,
               anode_err, frame_valid
    );
endinterface

// File: rtl/seven_seg_capture.sv
// Samples an active-low multiplexed seven-segment bus, debounces each
// anode/segment combination and rebuilds the four hex digits on display.
module seven_seg_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input logic           clk,
    input logic           reset_n,
    seven_seg_capture_if.slave bus
);
    localparam logic [7:0] LOCK_CNT = 8'(STABLE_CYCLES);
    localparam logic [7:0] LAST_CNT = 8'(STABLE_CYCLES - 1);

    logic [10:0]      s1, s2, prev;
    logic [7:0]       cnt;
    logic             match, accept;
    logic [3:0]       sel, hit, seen, seen_nxt;
    logic [6:0]       seg;
    logic [4:0]       dec;
    logic             one_hot, blank, store, perr;
    logic [3:0][3:0]  dig;
    logic [3:0]       dv, pe;
    logic             fv, ae;

    // {found, hex}; segments ordered g..a
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b1000000: decode = {1'b1, 4'h0};
            7'b1111001: decode = {1'b1, 4'h1};
            7'b0100100: decode = {1'b1, 4'h2};
            7'b0110000: decode = {1'b1, 4'h3};
            7'b0011001: decode = {1'b1, 4'h4};
            7'b0010010: decode = {1'b1, 4'h5};
            7'b0000010: decode = {1'b1, 4'h6};
            7'b1111000: decode = {1'b1, 4'h7};
            7'b0000000: decode = {1'b1, 4'h8};
            7'b0010000: decode = {1'b1, 4'h9};
            7'b0001000: decode = {1'b1, 4'hA};
            7'b0000011: decode = {1'b1, 4'hB};
            7'b1000110: decode = {1'b1, 4'hC};
            7'b0100001: decode = {1'b1, 4'hD};
            7'b0000110: decode = {1'b1, 4'hE};
            7'b0001110: decode = {1'b1, 4'hF};
            default:    decode = 5'b0;
        endcase
    endfunction

    // Synchronizer and stability tracking sit below clear on purpose.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1   <= '1;
            s2   <= '1;
            prev <= '1;
            cnt  <= '0;
        end else begin
            s1   <= {bus.anode_in, bus.segment_in};
            s2   <= s1;
            prev <= s2;
            if (!match)
                cnt <= '0;
            else if (cnt < LOCK_CNT)
                cnt <= cnt + 8'd1;
        end
    end

    assign match    = (s2 == prev);
    assign accept   = match && (cnt == LAST_CNT);
    assign sel      = ~s2[10:7];
    assign seg      = s2[6:0];
    assign dec      = decode(seg);
    assign one_hot  = $onehot(sel);
    assign blank    = &seg;
    assign store    = accept & one_hot & ~blank & dec[4];
    assign perr     = accept & one_hot & ~blank & ~dec[4];
    assign hit      = store ? sel : 4'b0;
    assign seen_nxt = seen | hit;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dig  <= '0;
            dv   <= '0;
            pe   <= '0;
            seen <= '0;
            fv   <= 1'b0;
            ae   <= 1'b0;
        end else if (bus.clear) begin
            dig  <= '0;
            dv   <= '0;
            pe   <= '0;
            seen <= '0;
            fv   <= 1'b0;
            ae   <= 1'b0;
        end else begin
            ae <= accept & (sel != 4'b0) & ~one_hot;
            for (int i = 0; i < 4; i++)
                if (hit[i]) dig[i] <= dec[3:0];
            dv   <= dv | hit;
            pe   <= pe | (perr ? sel : 4'b0);
            // completing a frame restarts the position tracking
            fv   <= (seen_nxt == 4'hF);
            seen <= (seen_nxt == 4'hF) ? 4'b0 : seen_nxt;
        end
    end

    assign bus.digitA      = dig[3];
    assign bus.digitB      = dig[2];
    assign bus.digitC      = dig[1];
    assign bus.digitD      = dig[0];
    assign bus.digit_valid = dv;
    assign bus.pattern_err = pe;
    assign bus.anode_err   = ae;
    assign bus.frame_valid = fv;
endmodule

// File: tb/tb_seven_seg_capture.sv
// Scoreboard bench: stimulus schedules accepts/clears into an event model,
// a negedge monitor compares every observable DUT change against it.
module tb_seven_seg_capture;
    localparam int S = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    seven_seg_capture_if bus();

    seven_seg_capture #(.STABLE_CYCLES(S)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] dig;   // A in [15:12] .. D in [3:0]
        logic [3:0]  dv;
        logic [3:0]  pe;
        logic        fv;
        logic        ae;
    } snap_t;
    typedef struct { int e; snap_t s; } exp_t;
    typedef struct { int e; bit clr; logic [10:0] v; } evt_t;

    exp_t  sb[$];
    evt_t  pend[$];
    int    errors = 0;
    int    checks = 0;
    int    cyc = 0;
    snap_t m, last;
    logic [3:0]  m_seen;
    logic [10:0] cur_v;
    int    run_start, run_len;
    bit    acc_done;
    logic [6:0] tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", n, got, exp);
        end
    endtask

    task automatic do_accept(input logic [10:0] v);
        logic [3:0] an;
        logic [6:0] sg;
        int low, pos, h;
        an = v[10:7]; sg = v[6:0]; low = 0; pos = 0; h = -1;
        for (int i = 0; i < 4; i++) if (!an[i]) begin low++; pos = i; end
        if (low > 1) m.ae = 1'b1;
        else if (low == 1 && sg != 7'h7F) begin
            for (int k = 0; k < 16; k++) if (tbl[k] == sg) h = k;
            if (h < 0) m.pe[pos] = 1'b1;
            else begin
                m.dig[pos*4 +: 4] = 4'(h);
                m.dv[pos] = 1'b1;
                m_seen[pos] = 1'b1;
                if (m_seen == 4'hF) begin m.fv = 1'b1; m_seen = 4'h0; end
            end
        end
    endtask

    task automatic proc(input int e);
        snap_t old;
        bit clr, has;
        logic [10:0] av;
        clr = 0; has = 0; av = '0;
        m.fv = 1'b0; m.ae = 1'b0;
        old = m;
        for (int i = pend.size() - 1; i >= 0; i--)
            if (pend[i].e == e) begin
                if (pend[i].clr) clr = 1;
                else begin has = 1; av = pend[i].v; end
                pend.delete(i);
            end
        if (clr) begin m.dig = '0; m.dv = '0; m.pe = '0; m_seen = '0; end
        else if (has) do_accept(av);
        if (m.fv || m.ae || {m.dig, m.dv, m.pe} != {old.dig, old.dv, old.pe})
            sb.push_back('{e: e, s: m});
    endtask

    task automatic tick();
        proc(cyc + 1);
        @(posedge clk);
        #1;
    endtask

    // Hold one bus value for h cycles; clear pulses on the clr_off-th edge.
    task automatic hold(input logic [3:0] an, input logic [6:0] sg, input int h, input int clr_off);
        logic [10:0] v;
        v = {an, sg};
        if (v != cur_v) begin
            cur_v = v; run_start = cyc; run_len = 0; acc_done = 0;
            bus.anode_in = an; bus.segment_in = sg;
        end
        run_len += h;
        if (!acc_done && run_len >= S + 1) begin
            pend.push_back('{e: run_start + S + 3, clr: 1'b0, v: v});
            acc_done = 1;
        end
        for (int i = 1; i <= h; i++) begin
            if (i == clr_off) begin
                bus.clear = 1'b1;
                pend.push_back('{e: cyc + 1, clr: 1'b1, v: 11'h0});
            end else bus.clear = 1'b0;
            tick();
        end
        bus.clear = 1'b0;
    endtask

    task automatic chk_zero(input string n);
        chk({n, "_digits"}, {16'h0, bus.digitA, bus.digitB, bus.digitC, bus.digitD}, 32'h0);
        chk({n, "_flags"}, {22'h0, bus.digit_valid, bus.pattern_err, bus.anode_err, bus.frame_valid}, 32'h0);
    endtask

    task automatic reset_mid();
        #6;
        reset_n = 1'b0;
        #1;
        chk_zero("midrst");
        pend.delete(); sb.delete();
        m = '0; m_seen = '0; last = '0;
        cur_v = 11'h7FF; acc_done = 1;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    always @(negedge clk) begin
        snap_t o;
        exp_t x;
        o.dig = {bus.digitA, bus.digitB, bus.digitC, bus.digitD};
        o.dv = bus.digit_valid; o.pe = bus.pattern_err;
        o.fv = bus.frame_valid; o.ae = bus.anode_err;
        if (!reset_n) last = '0;
        else begin
            if (o.fv || o.ae || {o.dig, o.dv, o.pe} != {last.dig, last.dv, last.pe}) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output edge=%0d got=%h", cyc, o);
                end else begin
                    x = sb.pop_front();
                    if (x.s !== o || x.e != cyc) begin
                        errors++;
                        $display("FAIL scoreboard edge=%0d got=%h exp=%h exp_edge=%0d", cyc, o, x.s, x.e);
                    end
                end
            end
            while (sb.size() > 0 && sb[0].e < cyc) begin
                x = sb.pop_front();
                checks++; errors++;
                $display("FAIL missed_output edge=%0d got=%h exp=%h", x.e, o, x.s);
            end
            last = o;
        end
    end

    initial begin
        int an_r, sg_r, h, co;
        logic [3:0] an;
        logic [6:0] sg;
        bus.anode_in = 4'hF; bus.segment_in = 7'h7F; bus.clear = 1'b0;
        m = '0; m_seen = '0; last = '0;
        cur_v = 11'h7FF; acc_done = 1; run_start = 0; run_len = 0;
        repeat (3) tick();
        chk_zero("reset");
        reset_n = 1'b1;

        hold(4'b0111, 7'b0100100, 10, -1);                 // basic: A=2
        chk("basic_digitA", {28'h0, bus.digitA}, 32'h2);
        chk("basic_valid", {28'h0, bus.digit_valid}, 32'h8);
        repeat (2) begin                                   // full frame twice
            hold(4'b0111, 7'b1111001, 8, -1);
            hold(4'b1011, 7'b0001000, 8, -1);
            hold(4'b1101, 7'b0001110, 8, -1);
            hold(4'b1110, 7'b1000000, 8, -1);
        end
        hold(4'b0111, 7'b0000000, 10, -1);                 // glitch rejection
        hold(4'b0111, 7'b1111001, 3, -1);
        hold(4'b0111, 7'b0000000, 10, -1);
        chk("glitch_digitA", {28'h0, bus.digitA}, 32'h8);
        hold(4'b1011, 7'b1010101, 10, -1);                 // error paths
        hold(4'b0011, 7'b0100100, 10, -1);
        hold(4'b1110, 7'b1111111, 10, -1);
        hold(4'b1111, 7'b1111111, 3, 2);                   // clear vs frame
        hold(4'b0111, 7'b1111001, 8, -1);
        hold(4'b1011, 7'b0001000, 8, -1);
        hold(4'b1101, 7'b0001110, 8, -1);
        hold(4'b1110, 7'b0000110, 8, S + 3);
        chk_zero("clear");

        repeat (150) begin                                 // randomized
            an_r = $urandom_range(0, 9);
            if (an_r < 6) an = ~(4'b1 << $urandom_range(0, 3));
            else an = 4'($urandom_range(0, 15));
            sg_r = $urandom_range(0, 7);
            if (sg_r < 5) sg = tbl[$urandom_range(0, 15)];
            else if (sg_r == 5) sg = 7'h7F;
            else sg = 7'($urandom_range(0, 127));
            h = $urandom_range(1, 9);
            co = ($urandom_range(0, 15) == 0) ? $urandom_range(1, h) : -1;
            hold(an, sg, h, co);
        end

        hold(4'b1011, 7'b0110000, 10, -1);
        hold(4'b1011, 7'b0100100, 3, -1);
        reset_mid();
        hold(4'b1101, 7'b0010010, 10, -1);                 // resume after reset
        chk("resume_digitC", {28'h0, bus.digitC}, 32'h5);
        chk("resume_valid", {28'h0, bus.digit_valid}, 32'h2);
        hold(4'b1111, 7'b1111111, 12, -1);
        chk("sb_drained", sb.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seven_seg_capture.md
# seven_seg_capture

Receive-side companion to the hex-to-seven-segment display driver: samples a time-multiplexed, active-low segment/anode bus and reconstructs the four hex digits being shown. Each anode/segment combination must hold steady before it is accepted. Accepted patterns are decoded back to hex and stored per digit position. The block pulses a frame strobe once all four positions have been captured. It is used for display loop-back self-test and for sniffing the display bus of another board.

## Interface
- STABLE_CYCLES, 4: consecutive matching samples required before a bus value is accepted; legal range is 1 to 255.
- clk  input  1  system clock; all flops sample on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- segment_in  input  7  active-low segments; bit 0 = a through bit 6 = g.
- anode_in  input  4  active-low digit enables; 0111 = A, 1011 = B, 1101 = C, 1110 = D.
- clear  input  1  synchronous clear of the capture state.
- digitA, digitB, digitC, digitD  output  4 each  last hex value accepted for each position.
- digit_valid  output  4  sticky per position (bit 3 = A … bit 0 = D); set on accept, reset by clear.
- pattern_err  output  4  sticky per position; set when a non-hex, non-blank pattern is accepted.
- anode_err  output  1  one-cycle pulse when an accepted sample has more than one anode low.
- frame_valid  output  1  one-cycle pulse when all four positions have been captured since the last frame.

## Operation
- **Synchronizer.** segment_in and anode_in pass through a two-flop synchronizer (s1, s2) as one 11-bit bus. The synchronizer flops reset to all 1s (inactive).
- **Change tracking.**
  - prev is loaded with s2 every cycle; it resets to all 1s.
  - match = (s2 == prev).
  - cnt is 8 bits. When match is 0, cnt loads 0. When match is 1, cnt increments and saturates at STABLE_CYCLES.
- **Accept condition.** accept = match AND (cnt == STABLE_CYCLES-1). This gives exactly one accept per stable run. There is no re-accept until the bus changes again.
- **States.**
  - TRACK is cnt < STABLE_CYCLES.
  - LOCKED is cnt == STABLE_CYCLES.
  - Any mismatch returns the block to TRACK.
- **Actions on accept, by anode value:**
  - All anodes high: ignored.
  - More than one anode low: anode_err pulses; nothing is stored.
  - Exactly one anode low, segments 1111111 (blank): ignored, no error.
  - Exactly one anode low, segments in the decode table: store the hex value in that digit's register, set its digit_valid bit and its seen bit.
  - Exactly one anode low, any other segment value: set that position's pattern_err bit; the digit register is unchanged.
- **Decode table (segments g..a → hex):**
  - 1000000→0, 1111001→1, 0100100→2, 0110000→3
  - 0011001→4, 0010010→5, 0000010→6, 1111000→7
  - 0000000→8, 0010000→9, 0001000→A, 0000011→B
  - 1000110→C, 0100001→D, 0000110→E, 0001110→F
- **Frame detection.**
  - seen[3:0] is internal.
  - When the next value of seen would be 1111, frame_valid is registered high for one cycle and seen is loaded with 0000 instead.
  - A re-capture of an already-seen position does not advance the frame.
- **Clear.**
  - Zeroes digit registers, digit_valid, pattern_err and seen.
  - Suppresses that cycle's accept side effects, including frame_valid and anode_err.
  - Clear wins over a simultaneous accept.
  - Does not touch the synchronizer, prev or cnt.
- **Reset values.** All outputs are 0; cnt is 0.

## Timing
- Edge numbering: edge 1 is the first rising edge that samples a changed input.
  - s2 holds the new value after edge 2.
  - prev holds the new value after edge 3; the first match occurs in that cycle.
  - accept is true in the cycle after edge STABLE_CYCLES+2.
  - The digit register and flags update at edge STABLE_CYCLES+3; with the default of 4 this is edge 7.
- frame_valid, anode_err and the pattern_err set all appear after the same edge as the corresponding digit update.
- An input glitch shorter than STABLE_CYCLES+1 cycles at the s2 stage produces no accept.
- reset_n asserted mid-run clears everything immediately. After release, capture restarts in TRACK with the synchronizer holding all 1s.
- Inputs are asynchronous to clk; the synchronizer is the only crossing.

## Test plan
- **Basic capture.** With STABLE_CYCLES=4, drive anode 0111 and segments 0100100 held for 10 cycles → after edge 7, digitA=2 and digit_valid=1000. No frame_valid and no errors.
- **Full frame.** Scan A=1, B=A, C=F, D=0, each held for 8 cycles → digits are 1/A/F/0. frame_valid pulses exactly once, on the D update; seen returns to 0. A second identical scan pulses frame_valid again.
- **Glitch rejection.** Hold A=8 stable; inject segment 1111001 for 3 cycles, then restore → digitA stays 8 and no accept occurs.
- **Error paths.**
  - Accepted pattern 1010101 on anode 1011 → pattern_err=0100 and digitB is unchanged.
  - Anode 0011 held stable → a single anode_err pulse; nothing is stored.
  - Blank 1111111 on anode 1110 → no flags change.
- **Clear and reset.** Assert clear in the same cycle as the accept of D that would complete a frame → no frame_valid, and all outputs are 0 next cycle. Assert reset_n low mid-run → all outputs are 0 asynchronously, and capture resumes correctly after release.
